vga_timing_gen: RTL

Parametrised VGA/SVGA raster timing generator.
- Divides the system clock into a pixel tick.
- Runs horizontal and vertical raster counters and decodes sync, blanking and line/frame markers.
- Sits between the clock/reset source and the pixel generator / frame-buffer reader.
- Generalises the fixed 640x480 sync block in four ways:
  - timing, divide ratio, sync polarity and counter width are parameters;
  - all decoded outputs are coherent with the pixel coordinates (no one-cycle skew);
  - an enable input is added;
  - line-start and frame-start strobes are added.

---
 rtl/vga_timing_pkg.sv | 43 ++++
 rtl/pixel_tick_div.sv | 32 +++
 rtl/vga_timing_gen.sv | 93 +++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Raster timing presets (640x480@60, 800x600@72) and total-count helpers
// shared by the VGA timing generator and its pixel tick divider.
package vga_timing_pkg;

   // 640x480@60 with a 25 MHz pixel from 50 MHz.
   localparam int VGA_DIV      = 2;
   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;
   localparam bit VGA_H_POL    = 1'b0;
   localparam bit VGA_V_POL    = 1'b0;
   localparam int VGA_CW       = 10;

   // 800x600@72 with a 50 MHz pixel.
   localparam int SVGA_DIV      = 1;
   localparam int SVGA_H_ACTIVE = 800;
   localparam int SVGA_H_FP     = 56;
   localparam int SVGA_H_SYNC   = 120;
   localparam int SVGA_H_BP     = 64;
   localparam int SVGA_V_ACTIVE = 600;
   localparam int SVGA_V_FP     = 37;
   localparam int SVGA_V_SYNC   = 6;
   localparam int SVGA_V_BP     = 23;
   localparam bit SVGA_H_POL    = 1'b1;
   localparam bit SVGA_V_POL    = 1'b1;
   localparam int SVGA_CW       = 11;

   function automatic int h_total(input int act, input int fp,
                                  input int sync, input int bp);
      return act + fp + sync + bp;
   endfunction

   function automatic int v_total(input int act, input int fp,
                                  input int sync, input int bp);
      return act + fp + sync + bp;
   endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// Pixel tick divider: p_tick is high for one clk every DIV enabled clks.
// Ports: clk_50M, rst (sync, active-high), en (freezes count), p_tick.
module pixel_tick_div
   import vga_timing_pkg::*;
#(
   parameter int DIV = VGA_DIV
) (
   input  logic clk_50M,
   input  logic rst,
   input  logic en,
   output logic p_tick
);

   // DIV=1 keeps a 1-bit counter pinned at 0, so p_tick reduces to en.
   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DW-1:0] LAST = DW'(DIV - 1);

   logic [DW-1:0] div_cnt;
   logic          at_last;

   assign at_last = (div_cnt == LAST);
   assign p_tick  = en & at_last;

   always_ff @(posedge clk_50M) begin
      if (rst) begin
         div_cnt <= '0;
      end else if (en) begin
         div_cnt <= at_last ? '0 : div_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel coordinates, sync, blanking and strobes.
// Ports: clk_50M, rst, en in; p_tick, pixel_x/y, video_on, h/vsync, line/frame_start out.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int DIV      = VGA_DIV,
   parameter int H_ACTIVE = VGA_H_ACTIVE,
   parameter int H_FP     = VGA_H_FP,
   parameter int H_SYNC   = VGA_H_SYNC,
   parameter int H_BP     = VGA_H_BP,
   parameter int V_ACTIVE = VGA_V_ACTIVE,
   parameter int V_FP     = VGA_V_FP,
   parameter int V_SYNC   = VGA_V_SYNC,
   parameter int V_BP     = VGA_V_BP,
   parameter bit H_POL    = VGA_H_POL,
   parameter bit V_POL    = VGA_V_POL,
   parameter int CW       = VGA_CW
) (
   input  logic          clk_50M,
   input  logic          rst,
   input  logic          en,
   output logic          p_tick,
   output logic [CW-1:0] pixel_x,
   output logic [CW-1:0] pixel_y,
   output logic          video_on,
   output logic          hsync,
   output logic          vsync,
   output logic          line_start,
   output logic          frame_start
);

   localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
   localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
   localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [CW-1:0] h_cnt;
   logic [CW-1:0] v_cnt;
   logic [CW-1:0] h_nxt;
   logic [CW-1:0] v_nxt;
   logic          h_wrap;
   logic          v_wrap;

   pixel_tick_div #(
      .DIV (DIV)
   ) u_div (
      .clk_50M (clk_50M),
      .rst     (rst),
      .en      (en),
      .p_tick  (p_tick)
   );

   always_comb begin
      h_wrap = (h_cnt == H_LAST);
      v_wrap = (v_cnt == V_LAST);
      h_nxt  = h_wrap ? '0 : h_cnt + 1'b1;
      v_nxt  = v_cnt;
      if (h_wrap) begin
         v_nxt = v_wrap ? '0 : v_cnt + 1'b1;
      end
   end

   // Decode registers load from the next coordinates so they line up
   // with pixel_x/pixel_y on the same edge.
   always_ff @(posedge clk_50M) begin
      if (rst) begin
         h_cnt    <= '0;
         v_cnt    <= '0;
         video_on <= 1'b1;
         hsync    <= ~H_POL;
         vsync    <= ~V_POL;
      end else if (p_tick) begin
         h_cnt    <= h_nxt;
         v_cnt    <= v_nxt;
         video_on <= (h_nxt < H_ACT) && (v_nxt < V_ACT);
         hsync    <= (h_nxt >= HS_BEG && h_nxt <= HS_END) ? H_POL : ~H_POL;
         vsync    <= (v_nxt >= VS_BEG && v_nxt <= VS_END) ? V_POL : ~V_POL;
      end
   end

   assign pixel_x     = h_cnt;
   assign pixel_y     = v_cnt;
   assign line_start  = p_tick & (h_cnt == '0);
   assign frame_start = line_start & (v_cnt == '0);

endmodule
